// File: rtl/coherent_mem_arbiter_if.sv
// Core/cache and RAM side bus of the coherent memory arbiter.
// slave: arbiter view; master: cores plus RAM model view.
interface coherent_mem_arbiter_if #(
  parameter int CPUS   = 4,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        ccwrite;
  logic [CPUS-1:0]        iwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] dload;
  logic [CPUS-1:0]        ccwait;
  logic [CPUS-1:0]        ccinv;
  logic [ADDR_W-1:0]      ccsnoopaddr;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload,
    output ccwait, ccinv, ccsnoopaddr,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload,
    input  ccwait, ccinv, ccsnoopaddr,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherent_mem_arbiter.sv
// N-core coherent memory arbiter: round-robin per class, snoop, c2c forward.
// Ports: CLK, nRST (sync, active-low), bus (slave side of the arbiter bus).
module coherent_mem_arbiter #(
  parameter int CPUS   = 4,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input logic CLK,
  input logic nRST,
  coherent_mem_arbiter_if.slave bus
);
  localparam int CW = (CPUS > 2) ? $clog2(CPUS) : 1;
  localparam logic [1:0] ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE, DWRITE, DSNOOP, DRAM, DFWD, IREAD
  } state_t;

  state_t        state;
  logic [CW-1:0] sel, owner, ptr_d, ptr_i;

  logic [ADDR_W-1:0] iaddr_a  [CPUS];
  logic [ADDR_W-1:0] daddr_a  [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];
  logic [WORD_W-1:0] iload_a  [CPUS];
  logic [WORD_W-1:0] dload_a  [CPUS];

  for (genvar g = 0; g < CPUS; g++) begin : g_slice
    assign iaddr_a[g]  = bus.iaddr[g*ADDR_W +: ADDR_W];
    assign daddr_a[g]  = bus.daddr[g*ADDR_W +: ADDR_W];
    assign dstore_a[g] = bus.dstore[g*WORD_W +: WORD_W];
    assign bus.iload[g*WORD_W +: WORD_W] = iload_a[g];
    assign bus.dload[g*WORD_W +: WORD_W] = dload_a[g];
  end

  logic [CPUS-1:0] wreq, rreq, ireq;
  logic [CPUS-1:0] sel_oh, others, dirty;
  logic [CW-1:0]   sel_nxt;
  logic            access;

  // a core raising dWEN and dREN together is served as a write only
  assign wreq    = bus.dWEN;
  assign rreq    = bus.dREN & ~bus.dWEN;
  assign ireq    = bus.iREN;
  assign sel_oh  = {{(CPUS-1){1'b0}}, 1'b1} << sel;
  assign others  = ~sel_oh;
  assign dirty   = bus.ccwrite & others;
  assign access  = bus.ramstate == ACCESS;
  assign sel_nxt = (sel == CW'(CPUS-1)) ? '0 : sel + 1'b1;

  // first requester at or above ptr, wrapping modulo CPUS
  function automatic logic [CW-1:0] pick(
    input logic [CPUS-1:0] req,
    input logic [CW-1:0]   ptr
  );
    logic [CW-1:0] idx;
    pick = ptr;
    for (int i = CPUS-1; i >= 0; i--) begin
      idx = CW'((int'(ptr) + i) % CPUS);
      if (req[idx]) pick = idx;
    end
  endfunction

  function automatic logic [CW-1:0] lowest(
    input logic [CPUS-1:0] req
  );
    lowest = '0;
    for (int i = CPUS-1; i >= 0; i--)
      if (req[i]) lowest = CW'(i);
  endfunction

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      sel   <= '0;
      owner <= '0;
      ptr_d <= '0;
      ptr_i <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|wreq) begin
            state <= DWRITE;
            sel   <= pick(wreq, ptr_d);
          end else if (|rreq) begin
            state <= DSNOOP;
            sel   <= pick(rreq, ptr_d);
          end else if (|ireq) begin
            state <= IREAD;
            sel   <= pick(ireq, ptr_i);
          end
        end
        DSNOOP: begin
          if (|dirty) begin
            state <= DFWD;
            owner <= lowest(dirty);
          end else begin
            state <= DRAM;
          end
        end
        DWRITE, DRAM, DFWD: begin
          if (access) begin
            ptr_d <= sel_nxt;
            state <= IDLE;
          end
        end
        IREAD: begin
          if (access) begin
            ptr_i <= sel_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    for (int k = 0; k < CPUS; k++) begin
      iload_a[k] = '0;
      dload_a[k] = '0;
    end
    unique case (state)
      DWRITE: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = daddr_a[sel];
        bus.ramstore = dstore_a[sel];
        if (access) bus.dwait[sel] = 1'b0;
      end
      DSNOOP: begin
        bus.ccsnoopaddr = daddr_a[sel];
        bus.ccwait      = others;
        bus.ccinv       = bus.ccwrite[sel] ? others : '0;
      end
      DRAM: begin
        bus.ccwait      = others;
        bus.ccsnoopaddr = daddr_a[sel];
        bus.ramREN      = 1'b1;
        bus.ramaddr     = daddr_a[sel];
        dload_a[sel]    = bus.ramload;
        if (access) bus.dwait[sel] = 1'b0;
      end
      DFWD: begin
        // owner's dirty word feeds the reader and the writeback together
        bus.ccwait      = others;
        bus.ccsnoopaddr = daddr_a[sel];
        dload_a[sel]    = dstore_a[owner];
        bus.ramWEN      = 1'b1;
        bus.ramaddr     = daddr_a[sel];
        bus.ramstore    = dstore_a[owner];
        if (access) begin
          bus.dwait[sel]   = 1'b0;
          bus.dwait[owner] = 1'b0;
        end
      end
      IREAD: begin
        bus.ramREN   = 1'b1;
        bus.ramaddr  = iaddr_a[sel];
        iload_a[sel] = bus.ramload;
        if (access) bus.iwait[sel] = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Scoreboard bench for coherent_mem_arbiter (CPUS=4).
// Directed vectors; completions checked by a separate monitor.
module tb_coherent_mem_arbiter;
  logic CLK;
  logic nRST;

  coherent_mem_arbiter_if bus ();

  coherent_mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]   iw;
    logic [3:0]   dw;
    logic [127:0] il;
    logic [127:0] dl;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'hCAFEF00D : (a ^ 32'h5A5A0000);
  endfunction

  assign bus.ramload = rd(bus.ramaddr);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: ACCESS on the 3rd consecutive cycle of a request
  initial begin
    int cnt;
    cnt = 0;
    bus.ramstate = 2'd0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.ramREN === 1'b1 || bus.ramWEN === 1'b1) begin
        cnt++;
        if (cnt >= 3) begin
          bus.ramstate = 2'd2;
          cnt = 0;
        end else begin
          bus.ramstate = 2'd1;
        end
      end else begin
        cnt = 0;
        bus.ramstate = 2'd0;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t mk();
    exp_t e;
    e.iw = 4'hF;
    e.dw = 4'hF;
    e.il = '0;
    e.dl = '0;
    return e;
  endfunction

  task automatic push_d(input logic [3:0] mask, input int k,
                        input logic [31:0] data);
    exp_t e;
    e = mk();
    e.dw = mask;
    e.dl[k*32 +: 32] = data;
    q.push_back(e);
  endtask

  task automatic push_i(input int k, input logic [31:0] data);
    exp_t e;
    e = mk();
    e.iw = 4'(~(4'b0001 << k));
    e.il[k*32 +: 32] = data;
    q.push_back(e);
  endtask

  // monitor: every cycle with a released wait is one completion
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.iwait !== 4'hF || bus.dwait !== 4'hF) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 128'({bus.iwait, bus.dwait}),
              128'(8'hFF));
        end else begin
          e = q.pop_front();
          chk("done_iwait", 128'(bus.iwait), 128'(e.iw));
          chk("done_dwait", 128'(bus.dwait), 128'(e.dw));
          chk("done_iload", bus.iload, e.il);
          chk("done_dload", bus.dload, e.dl);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_low(input bit d, input int k);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge CLK);
      if ((d ? bus.dwait[k] : bus.iwait[k]) === 1'b0) seen = 1'b1;
    end
    chk("wait_bound", 128'(seen), 128'(1'b1));
  endtask

  initial begin
    nRST        = 1'b0;
    bus.iREN    = 4'($urandom);
    bus.dREN    = 4'($urandom);
    bus.dWEN    = 4'($urandom);
    bus.ccwrite = 4'($urandom);
    bus.daddr   = '0;
    bus.dstore  = '0;
    for (int k = 0; k < 4; k++)
      bus.iaddr[k*32 +: 32] = 32'h1000 + 32'(k*4);

    // reset with random requests held for two edges
    tick();
    @(negedge CLK);
    chk("rst_waits", 128'({bus.iwait, bus.dwait}), 128'(8'hFF));
    chk("rst_ram", 128'({bus.ramREN, bus.ramWEN}), 128'(2'b00));
    tick();
    nRST        = 1'b1;
    bus.iREN    = '0;
    bus.dREN    = '0;
    bus.ccwrite = '0;
    bus.dWEN    = 4'b0010;
    bus.daddr[32 +: 32]  = 32'h40;
    bus.dstore[32 +: 32] = 32'h11;
    @(negedge CLK);
    chk("grant_c1", 128'({bus.ramREN, bus.ramWEN}), 128'(2'b00));
    tick();
    @(negedge CLK);
    chk("grant_c2", 128'({bus.ramWEN, bus.ramaddr, bus.ramstore}),
        128'({1'b1, 32'h40, 32'h11}));
    push_d(4'b1101, 1, 32'h0);
    wait_low(1'b1, 1);
    tick();
    bus.dWEN = '0;

    // round-robin on instruction reads
    tick();
    bus.iREN = 4'hF;
    for (int n = 0; n < 5; n++)
      push_i(n % 4, rd(32'h1000 + 32'((n % 4) * 4)));
    for (int n = 0; n < 5; n++) wait_low(1'b0, n % 4);
    tick();
    bus.iREN = '0;

    // class priority
    tick();
    bus.daddr[64 +: 32]  = 32'h300;
    bus.daddr[96 +: 32]  = 32'h400;
    bus.dstore[96 +: 32] = 32'h77;
    bus.iREN = 4'b0001;
    bus.dREN = 4'b0100;
    bus.dWEN = 4'b1000;
    push_d(4'b0111, 3, 32'h0);
    push_d(4'b1011, 2, rd(32'h300));
    push_i(0, rd(32'h1000));
    wait_low(1'b1, 3);
    tick();
    bus.dWEN = '0;
    wait_low(1'b1, 2);
    tick();
    bus.dREN = '0;
    wait_low(1'b0, 0);
    tick();
    bus.iREN = '0;

    // snoop miss
    tick();
    bus.daddr[32 +: 32] = 32'h100;
    bus.dREN = 4'b0010;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("miss_snoop",
        128'({bus.ccwait, bus.ccinv, bus.ramREN, bus.ccsnoopaddr}),
        128'({4'b1101, 4'b0000, 1'b0, 32'h100}));
    tick();
    @(negedge CLK);
    chk("miss_dram", 128'({bus.ccwait, bus.ramREN, bus.ramaddr}),
        128'({4'b1101, 1'b1, 32'h100}));
    push_d(4'b1101, 1, 32'hCAFEF00D);
    wait_low(1'b1, 1);
    tick();
    bus.dREN = '0;

    // dirty forward from lowest dirty core
    tick();
    bus.daddr[0 +: 32]   = 32'h200;
    bus.dstore[64 +: 32] = 32'h12345678;
    bus.dstore[96 +: 32] = 32'hDEADBEEF;
    bus.ccwrite = 4'b1100;
    bus.dREN    = 4'b0001;
    push_d(4'b1010, 0, 32'h12345678);
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("fwd_snoop", 128'({bus.ccwait, bus.ccinv}),
        128'({4'b1110, 4'b0000}));
    tick();
    @(negedge CLK);
    chk("fwd_wb",
        128'({bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore}),
        128'({2'b10, 32'h200, 32'h12345678}));
    wait_low(1'b1, 0);
    tick();
    bus.dREN    = '0;
    bus.ccwrite = '0;

    // read-for-modify, then reset mid-DRAM
    tick();
    bus.daddr[32 +: 32] = 32'h500;
    bus.ccwrite = 4'b0010;
    bus.dREN    = 4'b0010;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("rfm_inv", 128'({bus.ccwait, bus.ccinv}),
        128'({4'b1101, 4'b1101}));
    tick();
    @(negedge CLK);
    chk("rfm_dram", 128'({bus.ramREN, bus.ccinv}),
        128'({1'b1, 4'b0000}));
    tick();
    nRST        = 1'b0;
    bus.dREN    = '0;
    bus.ccwrite = '0;
    @(negedge CLK);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_mid", 128'({bus.ramREN, bus.ramWEN, bus.dwait}),
        128'({2'b00, 4'hF}));

    // pointer back at 0: core 0 wins over core 1
    tick();
    bus.daddr[0 +: 32]   = 32'h600;
    bus.daddr[32 +: 32]  = 32'h700;
    bus.dstore[0 +: 32]  = 32'hA0;
    bus.dstore[32 +: 32] = 32'hA1;
    bus.dWEN = 4'b0011;
    push_d(4'b1110, 0, 32'h0);
    push_d(4'b1101, 1, 32'h0);
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("ptr_rst", 128'({bus.ramaddr, bus.ramstore}),
        128'({32'h600, 32'hA0}));
    wait_low(1'b1, 0);
    tick();
    bus.dWEN[0] = 1'b0;
    wait_low(1'b1, 1);
    tick();
    bus.dWEN = '0;

    repeat (4) tick();
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
